// File: rtl/uart_cmd_responder_if.sv
// FIFO-side and register-bus signals shared between uart_cmd_responder (master) and its surroundings (slave).
interface uart_cmd_responder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_empty;
   logic                  rx_read;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_write;
   logic                  tx_full;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [7:0]            bus_wdata;
   logic                  bus_we;
   logic                  bus_req;
   logic [7:0]            bus_rdata;
   logic                  bus_ack;

   modport master (
      input  rx_data, rx_empty, tx_full, bus_rdata, bus_ack,
      output rx_read, tx_data, tx_write, bus_addr, bus_wdata, bus_we, bus_req
   );

   modport slave (
      output rx_data, rx_empty, tx_full, bus_rdata, bus_ack,
      input  rx_read, tx_data, tx_write, bus_addr, bus_wdata, bus_we, bus_req
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// Byte-protocol register responder between UART FIFOs and a simple register bus ('W' addr data / 'R' addr).
// Optional trailing XOR checksum byte per packet when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_responder #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int TIMEOUT_TICKS = 1000,
   parameter int BUS_TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   uart_cmd_responder_if.master bus,
   output logic                busy,
   output logic                cmd_error
);
   localparam int TCW = $clog2(TIMEOUT_TICKS + 1);
   localparam int BCW = $clog2(BUS_TIMEOUT + 1);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_POP  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
`ifdef UART_CMD_CHECKSUM_EN
   localparam logic [2:0] S_SUM  = 3'd4;
   localparam logic [2:0] S_AFTER_BODY = S_SUM;
`else
   localparam logic [2:0] S_AFTER_BODY = 3'd5;
`endif
   localparam logic [2:0] S_BUS  = 3'd5;
   localparam logic [2:0] S_RESP = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [2:0]            ret_q, ret_d;
   logic [7:0]            cmd_q, cmd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            data_q, data_d;
   logic [7:0]            reply_q, reply_d;
   logic [TCW-1:0]        tick_q, tick_d;
   logic [BCW-1:0]        busCnt_q, busCnt_d;
   logic                  cmdErr_q, cmdErr_d;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
`endif

   logic [7:0] rxByte;
   logic       isWrite;
   logic       inRecv;
   logic       tickDone;

   assign rxByte   = bus.rx_data[7:0];
   assign isWrite  = (cmd_q == CMD_W);
   assign tickDone = (tick_q == TCW'(TIMEOUT_TICKS));
`ifdef UART_CMD_CHECKSUM_EN
   assign inRecv   = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_SUM);
`else
   assign inRecv   = (state_q == S_ADDR) || (state_q == S_DATA);
`endif

   // A byte is latched in the receive state; rx_read pulses during the following POP gap.
   // When a byte arrives on the same cycle the inter-byte timeout expires, the byte wins.
   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      data_d   = data_q;
      reply_d  = reply_q;
      tick_d   = tick_q;
      busCnt_d = '0;
      cmdErr_d = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      if (inRecv && ce && !tickDone) begin
         tick_d = tick_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (!bus.rx_empty) begin
               cmd_d   = rxByte;
               state_d = S_POP;
`ifdef UART_CMD_CHECKSUM_EN
               sum_d   = rxByte;
`endif
               if (rxByte == CMD_W || rxByte == CMD_R) begin
                  ret_d = S_ADDR;
               end else begin
                  ret_d    = S_RESP;
                  reply_d  = NAK;
                  cmdErr_d = 1'b1;
               end
            end
         end
         S_POP: begin
            tick_d  = '0;
            state_d = ret_q;
         end
         S_ADDR: begin
            if (!bus.rx_empty) begin
               addr_d  = ADDR_WIDTH'(rxByte);
               state_d = S_POP;
               ret_d   = isWrite ? S_DATA : S_AFTER_BODY;
`ifdef UART_CMD_CHECKSUM_EN
               sum_d   = sum_q ^ rxByte;
`endif
            end else if (tickDone) begin
               state_d  = S_IDLE;
               cmdErr_d = 1'b1;
            end
         end
         S_DATA: begin
            if (!bus.rx_empty) begin
               data_d  = rxByte;
               state_d = S_POP;
               ret_d   = S_AFTER_BODY;
`ifdef UART_CMD_CHECKSUM_EN
               sum_d   = sum_q ^ rxByte;
`endif
            end else if (tickDone) begin
               state_d  = S_IDLE;
               cmdErr_d = 1'b1;
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         S_SUM: begin
            if (!bus.rx_empty) begin
               state_d = S_POP;
               if (rxByte == sum_q) begin
                  ret_d = S_BUS;
               end else begin
                  ret_d    = S_RESP;
                  reply_d  = NAK;
                  cmdErr_d = 1'b1;
               end
            end else if (tickDone) begin
               state_d  = S_IDLE;
               cmdErr_d = 1'b1;
            end
         end
`endif
         S_BUS: begin
            if (bus.bus_ack) begin
               state_d = S_RESP;
               reply_d = isWrite ? ACK : bus.bus_rdata;
            end else if (busCnt_q == BCW'(BUS_TIMEOUT - 1)) begin
               state_d  = S_RESP;
               reply_d  = NAK;
               cmdErr_d = 1'b1;
            end else begin
               busCnt_d = busCnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (!bus.tx_full) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         cmd_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         reply_q  <= '0;
         tick_q   <= '0;
         busCnt_q <= '0;
         cmdErr_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         reply_q  <= reply_d;
         tick_q   <= tick_d;
         busCnt_q <= busCnt_d;
         cmdErr_q <= cmdErr_d;
`ifdef UART_CMD_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   // Handshake outputs decode straight from registered state, so reset clears them at once.
   assign bus.rx_read   = (state_q == S_POP);
   assign bus.tx_write  = (state_q == S_RESP) && !bus.tx_full;
   assign bus.tx_data   = DATA_WIDTH'(reply_q);
   assign bus.bus_req   = (state_q == S_BUS);
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = data_q;
   assign bus.bus_we    = (state_q == S_BUS) && isWrite;
   assign busy          = (state_q != S_IDLE);
   assign cmd_error     = cmdErr_q;
endmodule
